branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Parametrised fetch-stage branch predictor (BTB + saturating-counter BHT, optional gshare).
//  Looks up pcF combinationally and supplies the predicted next PC to the PC mux.
//  Trains on branches/jumps resolved in Execute.
//  Flags mispredicts to hazard_unit (flush D/E) and keeps performance counters.
// PARAMETERS
//  ADDRESS_WIDTH  16  PC width in bits.
//  ENTRIES        64  BTB/BHT entries; power of 2; IDX_W = $clog2(ENTRIES).
//  CNT_WIDTH      2   Saturating counter width; MSB=1 predicts taken.
//  GHR_BITS       0   0 = bimodal; 1..IDX_W = gshare history length.
// PORTS
//  clk                 in   1       Clock; all state updates on rising edge.
//  rst                 in   1       Reset; asynchronous, active-low; clears all state.
//  pcF                 in   AW      Fetch PC.
//  pred_taken          out  1       Predict redirect (hit and (jump or counter MSB)).
//  pred_target         out  AW      Stored target if pred_taken, else pcF+4 (mod 2^AW).
//  pred_idx            out  IDX_W   Table index used; carried down the pipe to E.
//  update_valid        in   1       Branch/jump resolved in E this cycle.
//  update_pc           in   AW      PC of the resolved instruction.
//  update_idx          in   IDX_W   pred_idx carried with that instruction.
//  update_is_jump      in   1       Resolved instr is JAL/JALR.
//  update_taken        in   1       Actual outcome.
//  update_target       in   AW      Actual target.
//  update_pred_taken   in   1       Prediction that was made for it.
//  update_pred_target  in   AW      Predicted next PC that was used.
//  mispredict          out  1       Combinational; to hazard_unit flush logic.
//  branch_count        out  32      Resolved updates seen.
//  mispredict_count    out  32      Mispredicts seen.
// BEHAVIOUR
//  Entry fields: valid, tag = pc[AW-1:IDX_W+2], target[AW], is_jump, ctr[CNT_WIDTH].
//  Lookup index:
//   - GHR_BITS=0: pcF[IDX_W+1:2].
//   - Otherwise: pcF[IDX_W+1:2] ^ zero-extended ghr.
//  Lookup is purely combinational. hit = valid[idx] && tag match.
//  Write: update_valid at posedge writes entry update_idx.
//   - Hit: ctr saturating +1 if taken, -1 if not. Stop at max/0, no wrap.
//     On taken, target rewritten.
//   - Miss and taken: allocate. valid=1, tag, target, is_jump.
//     ctr = weakly taken (2^(CNT_WIDTH-1)).
//   - Miss and not taken: no write.
//   - is_jump: ctr forced to all-ones.
//  Same-cycle lookup and update of one index: lookup returns pre-update contents.
//  GHR: on update_valid && !update_is_jump, ghr <= {ghr[GHR_BITS-2:0], update_taken}.
//   Updated non-speculatively. Absent when GHR_BITS=0.
//  mispredict = update_valid && (update_taken != update_pred_taken
//               || (update_taken && update_target != update_pred_target)).
//  branch_count: +1 per update_valid.
//  mispredict_count: +1 per mispredict.
//  Both perf counters saturate at 32'hFFFF_FFFF.
//  Reset (rst=0, async):
//   - all valid=0, ctr=0, ghr=0, perf counters=0.
//   - Outputs then pred_taken=0, pred_target=pcF+4.
//   - An update coincident with reset is dropped.
//  Latency: prediction 0 cycles; training visible to lookups from the cycle after the update edge.
// STRUCTURE
//  bp_pkg: CTR_SNT/WNT/WT/ST encodings for CNT_WIDTH=2; perf counter width localparam (32).
//  Sub-module sat_counter #(WIDTH): saturating up/down with load.
//   Used for BHT entries and perf counters.
//  Tables are flop arrays (async clear needed); no SRAM macro.
// TESTING  (ENTRIES=64, AW=16, CNT_WIDTH=2, GHR_BITS=0 unless stated)
//  1. Reset, pcF=16'h0040 -> pred_taken=0, pred_target=16'h0044, counters=0.
//  2. Update pc=0x0040 taken, target=0x0080, pred_taken=0 -> mispredict=1.
//     Next cycle pcF=0x0040 -> pred_taken=1, target=0x0080, mispredict_count=1.
//  3. Two not-taken updates at 0x0040 -> ctr 10->01->00, pred_taken=0.
//     Third not-taken keeps ctr=00 (saturation).
//  4. Aliasing: train 0x0040, then lookup 0x0140 (same idx, tag differs) -> hit=0, pred 0x0144.
//  5. JAL at 0x0010 target 0x0100, one update -> pred_taken=1 immediately.
//     A later not-taken update does not clear is_jump.
//  6. Assert rst low mid-update with pending write -> entry not written; valid bits and counters read 0.
//  7. GHR_BITS=4: updates T,T,N -> ghr=4'b0110; pcF=0x0040 gives pred_idx=6'h16.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
// Counter encodings assume a 2-bit counter; wider counters use the generic helpers in the top.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TRAIN = 2'd1,
        UPD_ALLOC = 2'd2
    } upd_act_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with parallel load; clears asynchronously on rst low.
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next-value selection: load wins, otherwise step and stop at the rails.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_val;
        end else if (en && up && (count_r != {WIDTH{1'b1}})) begin
            count_next_s = count_r + WIDTH'(1'b1);
        end else if (en && !up && (count_r != {WIDTH{1'b0}})) begin
            count_next_s = count_r - WIDTH'(1'b1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_predictor.sv
// BTB + saturating-counter BHT with optional gshare indexing, combinational lookup,
// non-speculative training from Execute, mispredict flag and performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int ENTRIES       = 64,
    parameter int CNT_WIDTH     = 2,
    parameter int GHR_BITS      = 0,
    localparam int IDX_W        = $clog2(ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pcF,
    output logic                     pred_taken,
    output logic [ADDRESS_WIDTH-1:0] pred_target,
    output logic [IDX_W-1:0]         pred_idx,
    input  logic                     update_valid,
    input  logic [ADDRESS_WIDTH-1:0] update_pc,
    input  logic [IDX_W-1:0]         update_idx,
    input  logic                     update_is_jump,
    input  logic                     update_taken,
    input  logic [ADDRESS_WIDTH-1:0] update_target,
    input  logic                     update_pred_taken,
    input  logic [ADDRESS_WIDTH-1:0] update_pred_target,
    output logic                     mispredict,
    output logic [PERF_W-1:0]        branch_count,
    output logic [PERF_W-1:0]        mispredict_count
);

    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;
    localparam logic [CNT_WIDTH-1:0] CTR_WEAK_T = CNT_WIDTH'(1'b1) << (CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CTR_MAX    = {CNT_WIDTH{1'b1}};

    logic [ENTRIES-1:0]       valid_r;
    logic [ENTRIES-1:0]       is_jump_r;
    logic [TAG_W-1:0]         tag_r    [ENTRIES];
    logic [ADDRESS_WIDTH-1:0] target_r [ENTRIES];
    logic [CNT_WIDTH-1:0]     ctr_s    [ENTRIES];

    logic [IDX_W-1:0]         lookup_idx_s;
    logic                     hit_s;
    logic [ADDRESS_WIDTH-1:0] seq_pc_s;
    logic                     upd_hit_s;
    upd_act_e                 upd_act_s;
    logic                     unused_pc_bits_s;

    assign unused_pc_bits_s = ^update_pc[IDX_W+1:0];

    generate
        if (GHR_BITS > 0) begin : g_ghr
            logic [GHR_BITS-1:0] ghr_r;

            // Global history, shifted only by resolved conditional branches.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ghr_r <= {GHR_BITS{1'b0}};
                end else if (update_valid && !update_is_jump) begin
                    ghr_r <= (ghr_r << 1) | GHR_BITS'(update_taken);
                end else begin
                    ghr_r <= ghr_r;
                end
            end

            assign lookup_idx_s = pcF[IDX_W+1:2] ^ IDX_W'(ghr_r);
        end else begin : g_bimodal
            assign lookup_idx_s = pcF[IDX_W+1:2];
        end
    endgenerate

    assign hit_s       = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == pcF[ADDRESS_WIDTH-1:IDX_W+2]);
    assign seq_pc_s    = pcF + ADDRESS_WIDTH'(3'd4);
    assign pred_taken  = hit_s && (is_jump_r[lookup_idx_s] || ctr_s[lookup_idx_s][CNT_WIDTH-1]);
    assign pred_target = pred_taken ? target_r[lookup_idx_s] : seq_pc_s;
    assign pred_idx    = lookup_idx_s;

    assign upd_hit_s = valid_r[update_idx] && (tag_r[update_idx] == update_pc[ADDRESS_WIDTH-1:IDX_W+2]);

    // Classify the resolved instruction: train an existing entry, allocate, or leave the table alone.
    always_comb begin
        upd_act_s = UPD_NONE;
        if (!update_valid) begin
            upd_act_s = UPD_NONE;
        end else if (upd_hit_s) begin
            upd_act_s = UPD_TRAIN;
        end else if (update_taken) begin
            upd_act_s = UPD_ALLOC;
        end else begin
            upd_act_s = UPD_NONE;
        end
    end

    // BTB fields; is_jump is only set on allocation so later conditional updates keep it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r   <= {ENTRIES{1'b0}};
            is_jump_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {ADDRESS_WIDTH{1'b0}};
            end
        end else if (upd_act_s == UPD_ALLOC) begin
            valid_r[update_idx]   <= 1'b1;
            is_jump_r[update_idx] <= update_is_jump;
            tag_r[update_idx]     <= update_pc[ADDRESS_WIDTH-1:IDX_W+2];
            target_r[update_idx]  <= update_target;
        end else if ((upd_act_s == UPD_TRAIN) && update_taken) begin
            target_r[update_idx] <= update_target;
        end else begin
            valid_r <= valid_r;
        end
    end

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
            logic sel_s;
            assign sel_s = (update_idx == IDX_W'(i)) && (upd_act_s != UPD_NONE);

            sat_counter #(.WIDTH(CNT_WIDTH)) u_ctr (
                .clk      (clk),
                .rst      (rst),
                .en       (sel_s && (upd_act_s == UPD_TRAIN) && !update_is_jump),
                .up       (update_taken),
                .load     (sel_s && (update_is_jump || (upd_act_s == UPD_ALLOC))),
                .load_val (update_is_jump ? CTR_MAX : CTR_WEAK_T),
                .count    (ctr_s[i])
            );
        end
    endgenerate

    assign mispredict = update_valid &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken && (update_target != update_pred_target)));

    sat_counter #(.WIDTH(PERF_W)) u_branch_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (update_valid),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ({PERF_W{1'b0}}),
        .count    (branch_count)
    );

    sat_counter #(.WIDTH(PERF_W)) u_mispredict_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (mispredict),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ({PERF_W{1'b0}}),
        .count    (mispredict_count)
    );

endmodule
